// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: the active-low glyph table
// (index = hex value) and the segment bit positions on the probe bus.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_7_enc.sv
// Inverse of the display decoder: maps an active-low g..a pattern back to its
// hex nibble, flagging table hits and the all-off blank pattern.
import seg7_pkg::*;

module seg_7_enc (
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODE[i]) begin
        nibble = 4'(i);
        hit    = 1'b1;
      end
    end
  end

  assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg_7_reader.sv
// Probe-side reader for a scanned active-low 7-segment bus: synchronises the
// pins, waits for a stable window, then latches the decoded digit once.
import seg7_pkg::*;

module seg_7_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_pulse,
  output logic [2:0]              upd_idx,
  output logic                    upd_err
);

  localparam int         SW      = NUM_DIGITS + 8;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [SW-1:0]                sync1_q, sync2_q, prev_q;
  logic [7:0]                   cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]   hex_q, hex_d;
  logic [NUM_DIGITS-1:0]        dp_q, dp_d, vld_q, vld_d;
  logic                         pulse_q, pulse_d, err_q, err_d;
  logic [2:0]                   idx_q, idx_d;

  logic [NUM_DIGITS-1:0]        cur_dig;
  logic [7:0]                   cur_seg;
  logic [3:0]                   nlow;
  logic [2:0]                   sel_idx;
  logic [3:0]                   nibble;
  logic                         hit, blank, capture;

  assign {cur_dig, cur_seg} = sync2_q;

  seg_7_enc u_enc (
    .seg    (cur_seg[6:0]),
    .nibble (nibble),
    .hit    (hit),
    .blank  (blank)
  );

  always_comb begin
    nlow    = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!cur_dig[i]) begin
        nlow    = nlow + 4'd1;
        sel_idx = 3'(i);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != prev_q)    cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
  end

  // Fires only on the edge the counter reaches its ceiling, so a static bus
  // yields a single capture until something changes.
  assign capture = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX) && (nlow == 4'd1);

  always_comb begin
    hex_d   = hex_q;
    dp_d    = dp_q;
    vld_d   = vld_q;
    pulse_d = capture;
    err_d   = capture && !hit && !blank;
    idx_d   = capture ? sel_idx : idx_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && (sel_idx == 3'(i))) begin
        dp_d[i]  = ~cur_seg[SEG_DP];
        vld_d[i] = hit;
        if (hit) hex_d[i] = nibble;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
      hex_q   <= '0;
      dp_q    <= '0;
      vld_q   <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      sync1_q <= {dig_en, seg_in};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      vld_q   <= vld_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign hex_out     = hex_q;
  assign dp_out      = dp_q;
  assign digit_valid = vld_q;
  assign upd_pulse   = pulse_q;
  assign upd_err     = err_q;
  assign upd_idx     = idx_q;

endmodule

// File: tb/tb_seg_7_reader.sv
// Scoreboard bench for seg_7_reader (4 digits, 4-cycle stability window).
module tb_seg_7_reader;

  localparam int ND  = 4;
  localparam int ST  = 4;
  localparam int LAT = ST + 3;

  logic            clk, rst;
  logic [7:0]      seg_in;
  logic [ND-1:0]   dig_en;
  logic [4*ND-1:0] hex_out;
  logic [ND-1:0]   dp_out, digit_valid;
  logic            upd_pulse, upd_err;
  logic [2:0]      upd_idx;

  seg_7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
    .hex_out(hex_out), .dp_out(dp_out), .digit_valid(digit_valid),
    .upd_pulse(upd_pulse), .upd_idx(upd_idx), .upd_err(upd_err)
  );

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic       err;
    logic [3:0] hex;
    logic       vld;
    logic       dp;
  } exp_t;

  logic [6:0] CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] m_hex [ND];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pulse = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the head of the expectation queue, cycle included.
  always @(negedge clk) begin
    if (rst === 1'b0 && upd_pulse === 1'b1) begin
      n_pulse++;
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got idx=%0d err=%0b at cycle %0d, required no pulse",
                 upd_idx, upd_err, cyc);
      end else begin
        mon_e = q.pop_front();
        if (cyc !== mon_e.cyc || upd_idx !== mon_e.idx || upd_err !== mon_e.err) begin
          n_err++;
          $display("FAIL pulse_hdr: got cyc=%0d idx=%0d err=%0b, required cyc=%0d idx=%0d err=%0b",
                   cyc, upd_idx, upd_err, mon_e.cyc, mon_e.idx, mon_e.err);
        end
        n_cmp++;
        if (hex_out[4*mon_e.idx +: 4] !== mon_e.hex || digit_valid[mon_e.idx] !== mon_e.vld ||
            dp_out[mon_e.idx] !== mon_e.dp) begin
          n_err++;
          $display("FAIL pulse_data: digit %0d got hex=%h vld=%b dp=%b, required hex=%h vld=%b dp=%b",
                   mon_e.idx, hex_out[4*mon_e.idx +: 4], digit_valid[mon_e.idx], dp_out[mon_e.idx],
                   mon_e.hex, mon_e.vld, mon_e.dp);
        end
      end
    end
  end

  // Applies a bus state at the current negedge and holds it for 'hold' cycles;
  // when a capture is due, the expected result is queued from the bench table.
  task automatic drive(input logic [3:0] dig, input logic [7:0] seg, input int hold, input bit cap);
    exp_t       e;
    int         di;
    bit         hit;
    logic [3:0] n;
    dig_en = dig;
    seg_in = seg;
    if (cap) begin
      di = 0;
      for (int k = 0; k < ND; k++) if (!dig[k]) di = k;
      hit = 1'b0;
      n   = '0;
      for (int k = 0; k < 16; k++) if (seg[6:0] == CODES[k]) begin hit = 1'b1; n = 4'(k); end
      e.cyc = cyc + LAT;
      e.idx = 3'(di);
      e.err = !hit && (seg[6:0] != 7'h7F);
      e.hex = hit ? n : m_hex[di];
      e.vld = hit;
      e.dp  = ~seg[7];
      m_hex[di] = e.hex;
      q.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; dig_en = '1; seg_in = 8'hFF;
    for (int k = 0; k < ND; k++) m_hex[k] = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({hex_out, dp_out, digit_valid, upd_pulse, upd_idx, upd_err} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got hex=%h dp=%b vld=%b pulse=%b idx=%0d err=%b, required all 0",
               hex_out, dp_out, digit_valid, upd_pulse, upd_idx, upd_err);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_pulse !== 0) begin
      n_err++;
      $display("FAIL idle_bus: got %0d pulses, required 0", n_pulse);
    end
  endtask

  task automatic test_first_capture();
    int p0;
    drive(4'b1110, 8'hC0, 10, 1'b1);
    p0 = n_pulse;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (q.size() != 0 || hex_out[3:0] !== 4'h0 || digit_valid !== 4'b0001 || dp_out !== 4'b0000) begin
      n_err++;
      $display("FAIL first_capture: got pending=%0d hex=%h vld=%b dp=%b, required 0/0/0001/0000",
               q.size(), hex_out[3:0], digit_valid, dp_out);
    end
    n_cmp++;
    if (n_pulse !== p0) begin
      n_err++;
      $display("FAIL static_hold: got %0d extra pulses, required 0", n_pulse - p0);
    end
  endtask

  task automatic test_blank_err();
    drive(4'b1110, 8'hFF, 10, 1'b1);
    n_cmp++;
    if (digit_valid[0] !== 1'b0 || hex_out[3:0] !== 4'h0) begin
      n_err++;
      $display("FAIL blank: got vld0=%b hex0=%h, required 0/0", digit_valid[0], hex_out[3:0]);
    end
    drive(4'b1110, 8'h81, 10, 1'b1);
    n_cmp++;
    if (q.size() != 0 || digit_valid[0] !== 1'b0) begin
      n_err++;
      $display("FAIL bad_pattern: got pending=%0d vld0=%b, required 0/0", q.size(), digit_valid[0]);
    end
  endtask

  task automatic test_all_codes();
    for (int c = 0; c < 16; c++) drive(4'b1011, {1'b0, CODES[c]}, 10, 1'b1);
    n_cmp++;
    if (q.size() != 0 || hex_out[11:8] !== 4'hF || dp_out[2] !== 1'b1 || digit_valid[2] !== 1'b1) begin
      n_err++;
      $display("FAIL all_codes: got pending=%0d hex2=%h dp2=%b vld2=%b, required 0/f/1/1",
               q.size(), hex_out[11:8], dp_out[2], digit_valid[2]);
    end
  endtask

  task automatic test_no_capture();
    int p0;
    p0 = n_pulse;
    for (int j = 0; j < 8; j++) drive(4'b1110, {1'b1, CODES[j]}, (j % 2 == 0) ? 3 : 2, 1'b0);
    drive(4'b1100, 8'hC0, 10, 1'b0);
    drive(4'b1111, 8'hC0, 10, 1'b0);
    n_cmp++;
    if (n_pulse !== p0) begin
      n_err++;
      $display("FAIL no_capture: got %0d pulses, required 0", n_pulse - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = n_pulse;
    for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), {1'b1, CODES[d + 1]}, 10, 1'b1);
    n_cmp++;
    if (hex_out !== 16'h4321 || digit_valid !== 4'b1111 || dp_out !== 4'b0000 || n_pulse - p0 !== 4) begin
      n_err++;
      $display("FAIL round_robin: got hex=%h vld=%b dp=%b pulses=%0d, required 4321/1111/0000/4",
               hex_out, digit_valid, dp_out, n_pulse - p0);
    end
  endtask

  task automatic test_reset_midwindow();
    exp_t e;
    dig_en = 4'b1101;
    seg_in = {1'b1, CODES[5]};
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({hex_out, dp_out, digit_valid, upd_pulse, upd_idx, upd_err} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got hex=%h dp=%b vld=%b pulse=%b idx=%0d err=%b, required all 0",
               hex_out, dp_out, digit_valid, upd_pulse, upd_idx, upd_err);
    end
    for (int k = 0; k < ND; k++) m_hex[k] = '0;
    @(negedge clk);
    rst = 1'b0;
    e.cyc = cyc + LAT; e.idx = 3'd1; e.err = 1'b0; e.hex = 4'h5; e.vld = 1'b1; e.dp = 1'b0;
    q.push_back(e);
    repeat (12) @(negedge clk);
    n_cmp++;
    if (q.size() != 0 || hex_out !== 16'h0050 || digit_valid !== 4'b0010) begin
      n_err++;
      $display("FAIL post_reset: got pending=%0d hex=%h vld=%b, required 0/0050/0010",
               q.size(), hex_out, digit_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; dig_en = '1; seg_in = 8'hFF;
    @(negedge clk);
    test_reset();
    test_first_capture();
    test_blank_err();
    test_all_codes();
    test_no_capture();
    test_back_to_back();
    test_reset_midwindow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_7_reader.md
Name: seg_7_reader

Overview:
- Monitors a scanned, active-low 7-segment bus and recovers the hex digit shown on each position. Each position is selected by an active-low digit enable.
- Sits on the probe/loopback side of the display path. It lets NIOS-facing logic or a self-test read back what the display drivers are showing.
- Sequential core: input synchronisation, per-sample stability filtering, one-shot capture, and per-digit result registers.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (1..8).
- STABLE_CYCLES, 8, consecutive identical synchronised samples required before capture (2..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- seg_in  in  8  segment bus, active-low; bit7 = dp, bits6:0 = g..a.
- dig_en  in  NUM_DIGITS  digit enables, active-low; exactly one low selects a position.
- hex_out  out  4*NUM_DIGITS  recovered nibble per digit; digit i is at [4i+3:4i].
- dp_out  out  NUM_DIGITS  recovered decimal point per digit, active-high.
- digit_valid  out  NUM_DIGITS  digit holds a successfully decoded value.
- upd_pulse  out  1  one-cycle strobe: a capture occurred.
- upd_idx  out  3  digit index of the capture, valid with upd_pulse.
- upd_err  out  1  one-cycle strobe with upd_pulse: pattern not in table.

Behaviour:
- Reset (async, rst=1): all outputs are 0, the synchronisers are all-1 (idle bus), and the stability counter is 0.
- Synchronisation: seg_in and dig_en pass through a 2-flop synchroniser. A third register holds the previous synchronised sample.
- Stability counter:
  - Cleared to 0 when the current synchronised {dig_en, seg} differs from the previous sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture condition: the counter transitions to STABLE_CYCLES, which happens once per stable window.
  - Capture also requires exactly one dig_en bit low. With zero or multiple bits low, nothing is captured and no pulse is issued.
- Decode table, seg[6:0] to nibble, in hex code order 0..F: 40, 79, 24, 30, 19, 12, 02, 58, 00, 10, 08, 03, 46, 21, 06, 0E.
- Capture on digit i, by pattern:
  - Match: hex_out[i] is updated, digit_valid[i]=1, dp_out[i]=~seg[7], upd_pulse=1, upd_err=0.
  - Blank (seg[6:0]=7F): digit_valid[i]=0, hex_out[i] is held, dp_out[i] is updated, upd_pulse=1, upd_err=0.
  - Any other pattern: digit_valid[i]=0, hex_out[i] is held, dp_out[i] is updated, upd_pulse=1, upd_err=1.
- Outputs are registered and change on the capture edge. upd_pulse, upd_err and upd_idx are valid for exactly that cycle; upd_idx otherwise holds its last value.
- Latency: STABLE_CYCLES+3 clock edges from the first edge that samples the new pin value to upd_pulse high.
- Any change during the window restarts the count. A glitch shorter than STABLE_CYCLES never causes a capture.
- A bus held static indefinitely produces one capture only. A new capture requires a change followed by stability.
- Re-scanning the same digit with the same pattern after an intervening change re-captures and pulses again. The values are unchanged.
- Reset mid-window aborts the window; no capture occurs.

Decomposition:
- Package seg7_pkg holds:
  - SEG_CODE[16], the 7-bit active-low patterns listed above.
  - SEG_BLANK = 7'h7F.
  - The bit position constants for dp and a..g.
- Sub-module seg_7_enc, combinational:
  - Inputs: seg[6:0].
  - Outputs: nibble[3:0], hit, blank. It is the inverse of the display decoder table.
- The top level holds the synchronisers, the stability counter, the one-hot check, and the per-digit registers.

Test Plan (NUM_DIGITS=4, STABLE_CYCLES=4):
- Reset, then dig_en=1110 and seg_in=8'hC0 held. Required: upd_pulse exactly 7 edges later, upd_idx=0, hex_out[3:0]=0, digit_valid=0001, dp_out=0000, no further pulses while held.
- Scan all 16 codes with dp low on digit 2 (dig_en=1011), e.g. seg_in=8'h58. Required: hex_out[11:8]=7, dp_out[2]=1. All 16 codes must map correctly.
- After the first scenario, apply seg_in=8'hFF on digit 0. Required: upd_pulse with upd_err=0, digit_valid[0]=0, hex_out[3:0] still 0. Then apply seg_in=8'h81. Required: upd_err=1.
- Hold a pattern for 3 cycles, then change it, repeatedly. Required: no upd_pulse. Also apply dig_en=1100 or 1111 stable for 10 cycles. Required: no upd_pulse.
- Round-robin scan of digits 0..3 with codes 1, 2, 3, 4, each held 10 cycles. Required: hex_out=16'h4321, digit_valid=1111, four pulses with upd_idx 0, 1, 2, 3.
- Assert rst at counter=2 mid-window. Required: all outputs 0 immediately (asynchronously), no pulse after release until a fresh stable window completes.
